// File: rtl/spi_flash_pkg.sv
// ============================================================================
// Module  : spi_flash_pkg
// Brief   : Shared opcodes, frame geometry and FSM state encoding for spi_flash_sched
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_PAGE_PROG = 8'h02;
  localparam logic [7:0] OP_WREN      = 8'h06;

  localparam int FRAME_BYTES = 8;
  localparam int ADDR_BYTES  = 3;
  localparam int DATA_BYTES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : NREQ-wide round-robin pick; pointer moves to the winner on update
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  int            cand;

  assign any = |req;

  // Walk from the farthest candidate to the nearest so the first valid
  // index after the pointer is the last one written.
  always_comb begin
    grant_idx = ptr;
    cand      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NREQ;
      if (req[cand[IW-1:0]]) grant_idx = cand[IW-1:0];
    end
    grant = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= IW'(NREQ - 1);
    else if (update && any) ptr <= grant_idx;
  end

endmodule

`default_nettype wire

// File: rtl/spi_flash_sched.sv
// ============================================================================
// Module  : spi_flash_sched
// Brief   : Round-robin scheduler framing one 8-byte SPI NOR transaction per grant.
//           Optional macro SPI_FLASH_SCHED_WREN_EN prefixes writes with a 0x06 frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_sched
  import spi_flash_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic               p_clk,
  input  logic               p_reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [24*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               busy,
  output logic               s_clk,
  output logic               s_css,
  output logic [7:0]         s_mosi,
  input  logic [7:0]         s_miso
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);

`ifdef SPI_FLASH_SCHED_WREN_EN
  localparam bit WREN_ON = 1'b1;
`else
  localparam bit WREN_ON = 1'b0;
`endif

  state_e          state;
  logic [PW-1:0]   phase;
  logic [2:0]      byte_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [63:0]     frame;
  logic            is_write;
  logic            wren_pend;
  logic [NREQ-1:0] owner_oh;
  logic [31:0]     rd_shift;

  logic [NREQ-1:0] grant;
  logic            any_req;
  logic            win_write;
  logic [23:0]     win_addr;
  logic [31:0]     win_wdata;
  logic            last_phase;
  logic            sample;
  logic [31:0]     shift_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (p_clk),
    .rst_n  (p_reset_n),
    .req    (req_valid),
    .update (state == ST_ARB),
    .grant  (grant),
    .any    (any_req)
  );

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_write = req_write[i];
        win_addr  = req_addr[24*i +: 24];
        win_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  assign last_phase = (phase == PW'(2 * CLK_DIV - 1));
  // Read data bytes are captured on the first s_clk-high cycle of bytes 4..7.
  assign sample     = (state == ST_SHIFT) && (phase == PW'(CLK_DIV)) && byte_cnt[2]
                      && !is_write && !wren_pend;
  assign shift_next = sample ? {rd_shift[23:0], s_miso} : rd_shift;

  assign busy      = (state != ST_IDLE);
  assign s_css     = (state != ST_SHIFT);
  assign s_clk     = (state == ST_SHIFT) && (phase >= PW'(CLK_DIV));
  assign s_mosi    = (state != ST_SHIFT) ? 8'h00 : (wren_pend ? OP_WREN : frame[63:56]);
  assign req_ready = (state == ST_ARB) ? grant : '0;
  assign rsp_valid = (state == ST_DONE && !wren_pend) ? owner_oh : '0;

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state     <= ST_IDLE;
      phase     <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      frame     <= '0;
      is_write  <= 1'b0;
      wren_pend <= 1'b0;
      owner_oh  <= '0;
      rd_shift  <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) state <= ST_ARB;
        ST_ARB: begin
          if (any_req) begin
            is_write  <= win_write;
            owner_oh  <= grant;
            frame     <= {win_write ? OP_PAGE_PROG : OP_READ, win_addr,
                          win_write ? win_wdata : 32'h0};
            wren_pend <= WREN_ON && win_write;
            rd_shift  <= '0;
            phase     <= '0;
            byte_cnt  <= '0;
            state     <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          rd_shift <= shift_next;
          if (last_phase) begin
            phase <= '0;
            if (wren_pend) begin
              state <= ST_DONE;
            end else begin
              frame    <= {frame[55:0], 8'h00};
              byte_cnt <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd7) begin
                state     <= ST_DONE;
                rsp_rdata <= is_write ? 32'h0 : shift_next;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_DONE: begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            // After the write-enable frame, the real program frame follows.
            if (wren_pend) begin
              wren_pend <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
